// File: rtl/adc_scan_controller.sv
// Multi-channel SPI ADC scan controller: scans a channel mask per request, offset-corrects and windows
// each sample and writes it with its channel tag to the pixel FIFO. Define ADC_SCAN_INVERT_EN for dark-high output.
module adc_scan_controller #(
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned BIT_OFFSET = 1,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_BITS    = 2,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_start,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [7:0]          track_counts,
  input  logic [ADC_BITS-1:0] val_offset,
  input  logic                sdata,
  input  logic                fifo_full,
  output logic                sample_done,
  output logic                scan_done,
  output logic                busy,
  output logic                fifo_write_enable,
  output logic [OUT_BITS-1:0] fifo_write_data,
  output logic [CH_BITS-1:0]  fifo_write_ch,
  output logic                sclk,
  output logic                cs_n,
  output logic                din
);

  localparam int unsigned FRAME_PERIODS = LEAD_BITS + ADC_BITS;
  localparam int unsigned PER_W         = $clog2(FRAME_PERIODS + 1);
  localparam int unsigned DIV_W         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TIMER_W       = 8;

  typedef enum logic [2:0] {IDLE, TRACK, FRAME, WAIT_FIFO, NEXT} state_t;

  state_t              state;
  logic [NUM_CH-1:0]   scan_mask;
  logic [CH_BITS-1:0]  cur_ch;
  logic [CH_BITS-1:0]  adc_addr;
  logic [CH_BITS-1:0]  frame_ch;
  logic [TIMER_W-1:0]  timer;
  logic [PER_W-1:0]    period;
  logic [DIV_W-1:0]    div_cnt;
  logic [ADC_BITS-1:0] raw;
  logic                pending;

  logic                low_found;
  logic [CH_BITS-1:0]  low_idx;
  logic [CH_BITS-1:0]  next_addr;
  logic [ADC_BITS-1:0] diff;
  logic [ADC_BITS-1:0] shifted;
  logic [OUT_BITS-1:0] sat;
  logic [OUT_BITS-1:0] result;

  // Address bit driven on din during a given sclk period (MSB first in periods 1..CH_BITS).
  function automatic logic addr_bit(input logic [CH_BITS-1:0] addr, input logic [PER_W-1:0] p);
    logic [CH_BITS-1:0] sh;
    logic               b;
    sh = '0;
    b  = 1'b0;
    for (int k = 1; k <= int'(CH_BITS); k++) begin
      if (int'(p) == k) begin
        sh = addr >> (int'(CH_BITS) - k);
        b  = sh[0];
      end
    end
    return b;
  endfunction

  // Lowest remaining channel; it is also the address preloaded for the following frame.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (scan_mask[i]) begin
        low_found = 1'b1;
        low_idx   = CH_BITS'(i);
      end
    end
    next_addr = low_found ? low_idx : cur_ch;
  end

  // Saturating offset removal, then window, then optional polarity flip.
  always_comb begin
    diff    = raw - val_offset;
    shifted = diff >> BIT_OFFSET;
    if (raw < val_offset) begin
      sat = '0;
    end else if ((shifted >> OUT_BITS) != '0) begin
      sat = '1;
    end else begin
      sat = OUT_BITS'(shifted);
    end
`ifdef ADC_SCAN_INVERT_EN
    result = ~sat;
`else
    result = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      scan_mask         <= '0;
      cur_ch            <= '0;
      adc_addr          <= '0;
      frame_ch          <= '0;
      timer             <= '0;
      period            <= '0;
      div_cnt           <= '0;
      raw               <= '0;
      pending           <= 1'b0;
      sclk              <= 1'b1;
      cs_n              <= 1'b1;
      din               <= 1'b0;
      sample_done       <= 1'b0;
      scan_done         <= 1'b0;
      busy              <= 1'b0;
      fifo_write_enable <= 1'b0;
      fifo_write_data   <= '0;
      fifo_write_ch     <= '0;
    end else begin
      sample_done       <= 1'b0;
      scan_done         <= 1'b0;
      fifo_write_enable <= 1'b0;
      if (capture_start && state != IDLE) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture_start || pending) begin
            scan_mask <= ch_mask;
            busy      <= 1'b1;
            pending   <= 1'b0;
            state     <= NEXT;
          end
        end
        NEXT: begin
          if (low_found) begin
            cur_ch    <= low_idx;
            scan_mask <= scan_mask & ~(NUM_CH'(1) << low_idx);
            timer     <= '0;
            state     <= TRACK;
          end else begin
            scan_done <= 1'b1;
            // A request landing on the scan boundary chains straight into the next scan.
            if (capture_start || pending) begin
              scan_mask <= ch_mask;
              pending   <= 1'b0;
              state     <= NEXT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        TRACK: begin
          if (9'(timer) + 9'd1 >= 9'(track_counts)) begin
            cs_n        <= 1'b0;
            sclk        <= 1'b0;
            din         <= 1'b0;
            sample_done <= 1'b1;
            frame_ch    <= adc_addr;
            adc_addr    <= next_addr;
            period      <= '0;
            div_cnt     <= '0;
            state       <= FRAME;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        FRAME: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              if (period >= PER_W'(LEAD_BITS)) begin
                raw <= {raw[ADC_BITS-2:0], sdata};
              end
              if (period == PER_W'(FRAME_PERIODS - 1)) begin
                cs_n  <= 1'b1;
                sclk  <= 1'b1;
                state <= WAIT_FIFO;
              end else begin
                period <= period + PER_W'(1);
                sclk   <= 1'b0;
                din    <= addr_bit(adc_addr, period + PER_W'(1));
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        WAIT_FIFO: begin
          if (!fifo_full) begin
            fifo_write_enable <= 1'b1;
            fifo_write_data   <= result;
            fifo_write_ch     <= frame_ch;
            state             <= NEXT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Scoreboard bench for adc_scan_controller: behavioural ADC on the SPI pins, scan-order model and
// write/scan_done monitor. Honours ADC_SCAN_INVERT_EN.
module tb_adc_scan_controller;

  localparam int ADC_BITS   = 12;
  localparam int OUT_BITS   = 8;
  localparam int BIT_OFFSET = 1;
  localparam int NUM_CH     = 4;
  localparam int CH_BITS    = 2;
  localparam int LEAD_BITS  = 4;
  localparam int CLK_DIV    = 1;
  localparam int PERIODS    = LEAD_BITS + ADC_BITS;

  logic                clk = 1'b0;
  logic                reset;
  logic                capture_start;
  logic [NUM_CH-1:0]   ch_mask;
  logic [7:0]          track_counts;
  logic [ADC_BITS-1:0] val_offset;
  logic                sdata;
  logic                fifo_full;
  logic                sample_done;
  logic                scan_done;
  logic                busy;
  logic                fifo_write_enable;
  logic [OUT_BITS-1:0] fifo_write_data;
  logic [CH_BITS-1:0]  fifo_write_ch;
  logic                sclk;
  logic                cs_n;
  logic                din;

  adc_scan_controller dut (
    .clk(clk), .reset(reset), .capture_start(capture_start), .ch_mask(ch_mask),
    .track_counts(track_counts), .val_offset(val_offset), .sdata(sdata), .fifo_full(fifo_full),
    .sample_done(sample_done), .scan_done(scan_done), .busy(busy),
    .fifo_write_enable(fifo_write_enable), .fifo_write_data(fifo_write_data),
    .fifo_write_ch(fifo_write_ch), .sclk(sclk), .cs_n(cs_n), .din(din)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int ch; } wr_t;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  int  tag_q[$];
  int  addr_q[$];
  int  scan_q[$];
  int  raw_q[$];
  int  last_addr = 0;
  int  adc_idx   = 0;
  bit  adc_act   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected FIFO word from the arithmetic definition of offset, shift and clamp.
  function automatic int expect_data(input int raw, input int off);
    int d;
    int max_v;
    max_v = (1 << OUT_BITS) - 1;
    if (raw < off) d = 0;
    else d = (raw - off) / (1 << BIT_OFFSET);
    if (d > max_v) d = max_v;
`ifdef ADC_SCAN_INVERT_EN
    d = max_v - d;
`endif
    return d;
  endfunction

  // Scan-order model: frames convert the address sent one frame earlier.
  task automatic model_scan(input logic [NUM_CH-1:0] m);
    int bits[$];
    int n;
    for (int i = 0; i < NUM_CH; i++)
      if (((m >> i) & NUM_CH'(1)) != '0) bits.push_back(i);
    n = bits.size();
    scan_q.push_back(n);
    for (int k = 0; k < n; k++) begin
      tag_q.push_back((k == 0) ? last_addr : bits[k]);
      addr_q.push_back((k + 1 < n) ? bits[k+1] : bits[k]);
    end
    if (n > 0) last_addr = bits[n-1];
  endtask

  task automatic issue(input logic [NUM_CH-1:0] m);
    model_scan(m);
    ch_mask       = m;
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_full);
    int c;
    c = 0;
    while ((scan_q.size() != 0 || exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
      c++;
    end
    fifo_full = 1'b0;
    check("scan_within_budget", int'(c < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // Behavioural ADC: shifts a word out on sclk falling edges, captures din on rising edges.
  initial begin
    logic        pcs;
    logic        psclk;
    logic [15:0] word;
    logic [15:0] dinseq;
    int          raw;
    int          a;
    pcs    = 1'b1;
    psclk  = 1'b1;
    sdata  = 1'b0;
    word   = '0;
    dinseq = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        adc_act = 1'b0;
      end else begin
        if (pcs && !cs_n) begin
          raw = (raw_q.size() != 0) ? raw_q.pop_front() : int'($urandom_range(0, 4095));
          word    = {4'($urandom_range(0, 15)), 12'(raw)};
          sdata   = word[15];
          dinseq  = '0;
          adc_idx = 0;
          adc_act = 1'b1;
          check("tag_available", int'(tag_q.size() != 0), 1);
          if (tag_q.size() != 0) exp_q.push_back('{expect_data(raw, int'(val_offset)), tag_q.pop_front()});
        end else if (adc_act && !cs_n && psclk && !sclk) begin
          adc_idx++;
          word  = word << 1;
          sdata = word[15];
        end
        if (adc_act && !cs_n && !psclk && sclk) dinseq = {dinseq[14:0], din};
        if (adc_act && !pcs && cs_n) begin
          adc_act = 1'b0;
          check("frame_periods", adc_idx + 1, PERIODS);
          check("addr_available", int'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            check("din_sequence", int'(dinseq), a << (PERIODS - 1 - CH_BITS));
          end
        end
      end
      pcs   = cs_n;
      psclk = sclk;
    end
  end

  // Monitor: pops expected writes and per-scan counts as the DUT presents them.
  initial begin
    wr_t e;
    int  nwr;
    int  nsd;
    int  n;
    nwr = 0;
    nsd = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        nwr = 0;
        nsd = 0;
      end else begin
        if (fifo_write_enable) begin
          check("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_data", int'(fifo_write_data), e.data);
            check("wr_ch", int'(fifo_write_ch), e.ch);
          end
          nwr++;
        end
        if (sample_done) nsd++;
        if (scan_done) begin
          check("scan_done_expected", int'(scan_q.size() != 0), 1);
          if (scan_q.size() != 0) begin
            n = scan_q.pop_front();
            check("scan_writes", nwr, n);
            check("scan_samples", nsd, n);
          end
          nwr = 0;
          nsd = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int low;
    int wr_seen;
    logic [NUM_CH-1:0] m;
    reset         = 1'b1;
    capture_start = 1'b0;
    ch_mask       = '0;
    track_counts  = 8'd14;
    val_offset    = '0;
    fifo_full     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_outputs",
            int'({sclk, cs_n, din, sample_done, scan_done, busy, fifo_write_enable, fifo_write_data, fifo_write_ch}),
            int'({7'b1100000, 10'd0}));
    end
    @(negedge clk);

    // Single channel: track latency, frame length, data 0xD2 on ch0
    val_offset   = 12'h100;
    track_counts = 8'd14;
    raw_q.push_back(12'h2A5);
    issue(4'b0001);
    cnt = 0;
    while (!sample_done && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    // edges after the accepting edge: one NEXT cycle plus track_counts TRACK cycles
    check("track_latency", cnt, int'(track_counts) + 1);
    low = 0;
    while (cs_n == 1'b0 && low < 1000) begin
      low++;
      @(posedge clk); #1;
    end
    check("cs_low_cycles", low, 2 * CLK_DIV * PERIODS);
    wait_done(2000, 1'b0);

    // Saturation at both ends
    val_offset = 12'h100;
    raw_q.push_back(12'h050);
    issue(4'b0001);
    wait_done(2000, 1'b0);
    val_offset = 12'h000;
    raw_q.push_back(12'hFFF);
    issue(4'b0001);
    wait_done(2000, 1'b0);

    // Prior ch1 frame, then mask 1010
    val_offset = 12'h020;
    issue(4'b0010);
    wait_done(2000, 1'b0);
    issue(4'b1010);
    wait_done(2000, 1'b0);

    // FIFO stall with a request pended during the stall
    fifo_full = 1'b1;
    issue(4'b0100);
    cnt = 0;
    while (cs_n == 1'b1 && cnt < 500) begin @(posedge clk); #1; cnt++; end
    while (cs_n == 1'b0 && cnt < 500) begin @(posedge clk); #1; cnt++; end
    check("stall_frame_end_seen", int'(cnt < 500), 1);
    wr_seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      capture_start = (c == 10);
      if (c == 10) model_scan(4'b0100);
      @(posedge clk); #1;
      if (fifo_write_enable || !sclk || !cs_n) wr_seen++;
    end
    check("stall_quiet_cycles", wr_seen, 0);
    @(negedge clk);
    fifo_full = 1'b0;
    cnt = 0;
    while (!scan_done && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("pended_scan_keeps_busy", int'({scan_done, busy}), 3);
    @(negedge clk);
    wait_done(2000, 1'b0);

    // Reset in the middle of a frame
    track_counts = 8'd3;
    issue(4'b0001);
    cnt = 0;
    while (!(adc_act && adc_idx == 8) && cnt < 500) begin @(negedge clk); cnt++; end
    check("reached_period_8", int'(cnt < 500), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_frame", int'({cs_n, sclk, busy, fifo_write_enable}), 4'b1100);
    @(negedge clk);
    exp_q.delete();
    tag_q.delete();
    addr_q.delete();
    scan_q.delete();
    raw_q.delete();
    last_addr = 0;
    reset     = 1'b0;
    wr_seen   = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (fifo_write_enable || busy) wr_seen++;
    end
    check("quiet_after_reset", wr_seen, 0);
    @(negedge clk);
    val_offset = 12'h010;
    raw_q.push_back(12'h3C7);
    issue(4'b0001);
    wait_done(2000, 1'b0);

    // Randomised scans with random back-pressure and occasional pended requests
    for (int it = 0; it < 25; it++) begin
      m            = 4'($urandom_range(0, 15));
      track_counts = 8'($urandom_range(0, 12));
      val_offset   = 12'($urandom_range(0, 4095) >> $urandom_range(0, 6));
      issue(m);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        issue(m);
      end
      wait_done(8000, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
